// File: rtl/tone_meter.sv
// ============================================================================
// tone_meter
// ----------------------------------------------------------------------------
// Measures the half-period of a square-wave tone that arrives asynchronously
// to clk. The result is reported in the same "divider" encoding that the tone
// generator uses: a generator that toggles every D+1 clocks is measured as D.
//
// Optional feature (compile-time macro):
//   TONE_METER_MATCH_FILTER_EN
//      defined   : two consecutive equal samples are needed before the
//                  measurement locks (and before it re-locks after a change).
//      undefined : every sample taken in ARM or MEAS loads the divider and
//                  locks at once. In LOCK a differing sample reloads the
//                  divider and the meter stays locked.
//
// Parameters:
//   SYNC_STAGES : number of input synchronizer flops, legal range 2..4.
//
// Ports:
//   clk      in   1   system clock, all state changes on its rising edge
//   reset    in   1   synchronous, active-high reset
//   audio_in in   1   square-wave tone, asynchronous to clk
//   divider  out  16  measured half-period minus one, in clk cycles
//   valid    out  1   high while divider holds a locked measurement
//   update   out  1   one-cycle pulse whenever divider is loaded
//   no_tone  out  1   high while no edges are being received (IDLE)
// ============================================================================
module tone_meter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        audio_in,
   output logic [15:0] divider,
   output logic        valid,
   output logic        update,
   output logic        no_tone
);

   // ------------------------------------------------------------------------
   // Input synchronizer plus one extra flop for edge detection
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] w_sync_d;
   logic                   r_edge_ff;
   logic                   w_edge;

   // Shift-register input vector built per stage so the whole chain is
   // updated from a single sequential process.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign w_sync_d[gi] = audio_in;
         end else begin : g_rest
            assign w_sync_d[gi] = r_sync[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync    <= '0;
         r_edge_ff <= 1'b0;
      end else begin
         r_sync    <= w_sync_d;
         r_edge_ff <= r_sync[SYNC_STAGES-1];
      end
   end

   // Both rising and falling transitions count: each one marks a half-period.
   assign w_edge = r_sync[SYNC_STAGES-1] ^ r_edge_ff;

   // ------------------------------------------------------------------------
   // Interval counter
   // ------------------------------------------------------------------------
   // Cleared in the edge cycle, so at the next edge it holds exactly the
   // number of clocks between edges minus one, i.e. the generator's divider.
   logic [15:0] r_cnt;
   logic        w_cnt_sat;
   logic [15:0] w_sample;

   assign w_cnt_sat = &r_cnt;
   assign w_sample  = r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_edge) begin
         r_cnt <= '0;
      end else if (!w_cnt_sat) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2,
      LOCK = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_divider;
   logic [15:0] w_divider_next;
   logic        r_update;
   logic        w_update_next;
   logic        w_timeout;

   // An edge in the saturation cycle is a legal 16'hFFFF sample, so the
   // timeout only fires when no edge arrives alongside saturation.
   assign w_timeout = w_cnt_sat && !w_edge && (r_state != IDLE);

`ifdef TONE_METER_MATCH_FILTER_EN
   // Candidate sample awaiting confirmation by an equal follow-up sample.
   logic [15:0] r_cand;
   logic [15:0] w_cand_next;

   always_comb begin
      w_state_next   = r_state;
      w_divider_next = r_divider;
      w_update_next  = 1'b0;
      w_cand_next    = r_cand;

      case (r_state)
         IDLE: begin
            // First edge only marks a starting point; no interval yet.
            if (w_edge) begin
               w_state_next = ARM;
            end
         end
         ARM: begin
            if (w_edge) begin
               w_cand_next  = w_sample;
               w_state_next = MEAS;
            end
         end
         MEAS: begin
            if (w_edge) begin
               if (w_sample == r_cand) begin
                  w_divider_next = w_sample;
                  w_update_next  = 1'b1;
                  w_state_next   = LOCK;
               end else begin
                  w_cand_next = w_sample;
               end
            end
         end
         LOCK: begin
            // A differing sample drops the lock but leaves the old divider
            // visible until a new value has been confirmed.
            if (w_edge && (w_sample != r_divider)) begin
               w_cand_next  = w_sample;
               w_state_next = MEAS;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      if (w_timeout) begin
         w_state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cand <= '0;
      end else begin
         r_cand <= w_cand_next;
      end
   end
`else
   always_comb begin
      w_state_next   = r_state;
      w_divider_next = r_divider;
      w_update_next  = 1'b0;

      case (r_state)
         IDLE: begin
            // First edge only marks a starting point; no interval yet.
            if (w_edge) begin
               w_state_next = ARM;
            end
         end
         ARM, MEAS: begin
            if (w_edge) begin
               w_divider_next = w_sample;
               w_update_next  = 1'b1;
               w_state_next   = LOCK;
            end
         end
         LOCK: begin
            // Unfiltered: follow every change immediately while staying locked.
            if (w_edge && (w_sample != r_divider)) begin
               w_divider_next = w_sample;
               w_update_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      if (w_timeout) begin
         w_state_next = IDLE;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_divider <= '0;
         r_update  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_divider <= w_divider_next;
         r_update  <= w_update_next;
      end
   end

   // valid / no_tone are pure state decodes of a registered state, so they
   // change on the same clock as the state and need no extra flops.
   assign divider = r_divider;
   assign update  = r_update;
   assign valid   = (r_state == LOCK);
   assign no_tone = (r_state == IDLE);

endmodule

// File: tb/tb_tone_meter.sv
// ============================================================================
// tb_tone_meter
// ----------------------------------------------------------------------------
// Directed bench for tone_meter. audio_in is toggled between clock edges; a
// toggle placed after clock k becomes an edge cycle that ends at clock k+3
// (SYNC_STAGES=2), where divider/update are loaded. Holding audio_in for
// len clocks between toggles produces a sample of len-1.
// Expected values depend on TONE_METER_MATCH_FILTER_EN and are selected by
// the FILT constant below.
// ============================================================================
module tb_tone_meter;

   logic        clk;
   logic        reset;
   logic        audio_in;
   logic [15:0] divider;
   logic        valid;
   logic        update;
   logic        no_tone;

   int checks = 0;
   int errors = 0;

`ifdef TONE_METER_MATCH_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   tone_meter #(.SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .audio_in (audio_in),
      .divider  (divider),
      .valid    (valid),
      .update   (update),
      .no_tone  (no_tone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait so the toggle spacing is len clocks, toggle, then check the outputs
   // on the loading clock and that update is low one clock later.
   task automatic step(input int len, input string tag, input logic eu,
                       input logic [15:0] ed, input logic ev, input logic en);
      tick(len - 4);
      audio_in = ~audio_in;
      tick(3);
      chk({tag, ".update"},  {31'd0, update},  {31'd0, eu});
      chk({tag, ".divider"}, {16'd0, divider}, {16'd0, ed});
      chk({tag, ".valid"},   {31'd0, valid},   {31'd0, ev});
      chk({tag, ".no_tone"}, {31'd0, no_tone}, {31'd0, en});
      tick(1);
      chk({tag, ".upd_low"}, {31'd0, update}, 32'd0);
      $display("step %s: len=%0d divider=%0d valid=%0d update_seen=%0d", tag, len, divider, valid, eu);
   endtask

   initial begin
      reset    = 1'b1;
      audio_in = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst.divider", {16'd0, divider}, 32'd0);
      chk("rst.valid",   {31'd0, valid},   32'd0);
      chk("rst.update",  {31'd0, update},  32'd0);
      chk("rst.no_tone", {31'd0, no_tone}, 32'd1);
      $display("reset: divider=%0d valid=%0d update=%0d no_tone=%0d", divider, valid, update, no_tone);

      // First edge only arms; then samples 10, 12, 12.
      step(20, "arm", 1'b0, 16'd0, 1'b0, 1'b0);
      step(11, "s10",  FILT ? 1'b0 : 1'b1, FILT ? 16'd0 : 16'd10, FILT ? 1'b0 : 1'b1, 1'b0);
      step(13, "s12a", FILT ? 1'b0 : 1'b1, FILT ? 16'd0 : 16'd12, FILT ? 1'b0 : 1'b1, 1'b0);
      step(13, "s12b", FILT ? 1'b1 : 1'b0, 16'd12, 1'b1, 1'b0);

      // Generator D=99.
      step(100, "d99a", FILT ? 1'b0 : 1'b1, FILT ? 16'd12 : 16'd99, FILT ? 1'b0 : 1'b1, 1'b0);
      step(100, "d99b", FILT ? 1'b1 : 1'b0, 16'd99, 1'b1, 1'b0);
      step(100, "d99c", 1'b0, 16'd99, 1'b1, 1'b0);

      // Switch to D=49.
      step(50, "d49a", FILT ? 1'b0 : 1'b1, FILT ? 16'd99 : 16'd49, FILT ? 1'b0 : 1'b1, 1'b0);
      step(50, "d49b", FILT ? 1'b1 : 1'b0, 16'd49, 1'b1, 1'b0);
      step(50, "d49c", 1'b0, 16'd49, 1'b1, 1'b0);

      // Back to D=99 before letting the input go silent.
      step(100, "d99d", FILT ? 1'b0 : 1'b1, FILT ? 16'd49 : 16'd99, FILT ? 1'b0 : 1'b1, 1'b0);
      step(100, "d99e", FILT ? 1'b1 : 1'b0, 16'd99, 1'b1, 1'b0);

      // Timeout: last edge ended at clock E, we are at E+1 (cnt=1).
      // cnt saturates at E+65535, IDLE is entered at E+65536.
      tick(65533);
      chk("to.valid_before", {31'd0, valid}, 32'd1);
      tick(1);
      chk("to.valid_sat",    {31'd0, valid}, 32'd1);
      chk("to.no_tone_sat",  {31'd0, no_tone}, 32'd0);
      tick(1);
      chk("to.valid",   {31'd0, valid},   32'd0);
      chk("to.no_tone", {31'd0, no_tone}, 32'd1);
      chk("to.divider", {16'd0, divider}, 32'd99);
      chk("to.update",  {31'd0, update},  32'd0);
      $display("timeout: divider=%0d valid=%0d no_tone=%0d", divider, valid, no_tone);

      // Generator D=0: audio_in toggles every clock.
      repeat (12) begin
         audio_in = ~audio_in;
         tick(1);
      end
      chk("d0.divider", {16'd0, divider}, 32'd0);
      chk("d0.valid",   {31'd0, valid},   32'd1);
      chk("d0.no_tone", {31'd0, no_tone}, 32'd0);
      chk("d0.update",  {31'd0, update},  32'd0);
      $display("d0: divider=%0d valid=%0d", divider, valid);

      // One-cycle reset mid-stream.
      reset    = 1'b1;
      audio_in = ~audio_in;
      tick(1);
      chk("mrst.divider", {16'd0, divider}, 32'd0);
      chk("mrst.valid",   {31'd0, valid},   32'd0);
      chk("mrst.update",  {31'd0, update},  32'd0);
      chk("mrst.no_tone", {31'd0, no_tone}, 32'd1);
      reset    = 1'b0;
      audio_in = ~audio_in;
      tick(1);
      chk("mrst.valid_after", {31'd0, valid}, 32'd0);
      $display("mid-reset: divider=%0d valid=%0d no_tone=%0d", divider, valid, no_tone);

      repeat (10) begin
         audio_in = ~audio_in;
         tick(1);
      end
      chk("relock.valid",   {31'd0, valid},   32'd1);
      chk("relock.divider", {16'd0, divider}, 32'd0);
      chk("relock.no_tone", {31'd0, no_tone}, 32'd0);
      $display("relock: divider=%0d valid=%0d", divider, valid);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
